pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline scheduler for the five-stage MIPS core. It sits between the ID stage and the ID/EX pipeline register and decides each cycle whether the PC, IF/ID and ID/EX advance, hold, flush or take a bubble. It detects load-use hazards, applies taken-branch flushes and holds the pipeline while a multi-cycle EX operation (mult/div) occupies the EX stage. Downstream of it, the ID/EX register gains a write enable and a bubble input that zeroes its WB/M/EX control fields.

## Interface
- MC_LAT, 4: cycles a multi-cycle op occupies EX (≥1).
- REG_W, 5: register-address width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  REG_W  Rs of the instruction in ID.
- id_rt  in  REG_W  Rt of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads Rt as a source.
- id_mc_op  in  1  ID instruction is multi-cycle.
- ex_mem_read  in  1  EX instruction is a load (ID/EX M field MemRead bit).
- ex_dst  in  REG_W  load destination in EX (ID/EX I-type address).
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_we  out  1  ID/EX write enable.
- idex_bubble  out  1  ID/EX loads zero control (WB/M/EX = 0).
- mc_busy  out  1  multi-cycle op held in EX.
- Under HAZARD_STATS_EN: lu_cnt, flush_cnt, mc_cnt  out  32 each.

## Operation
- States: RUN, MC_BUSY. There is a REG_W-wide down-counter `cnt` (wide enough for MC_LAT−1).
- Load-use hazard (lu), evaluated in RUN only:
  - lu = ex_mem_read && ex_dst≠0 && (ex_dst==id_rs || (id_uses_rt && ex_dst==id_rt)).
- RUN, priority from highest:
  1. ex_branch_taken: pc_we=1, ifid_we=1, ifid_flush=1, idex_we=1, idex_bubble=1. Any lu is ignored.
  2. lu: pc_we=0, ifid_we=0, idex_we=1, idex_bubble=1. This is a one-cycle stall.
  3. Otherwise: all enables are 1 and both flush/bubble are 0.
- RUN→MC_BUSY on an edge where id_mc_op=1 and the case-3 advance occurs. cnt is loaded with MC_LAT−1. If MC_LAT=1, MC_BUSY is never entered.
- MC_BUSY:
  - Outputs: pc_we=0, ifid_we=0, idex_we=0, idex_bubble=0, ifid_flush=0, mc_busy=1.
  - ex_branch_taken and lu are ignored.
  - cnt decrements each cycle. On the edge where cnt==1, the block returns to RUN.
- An id_mc_op that is stalled by lu or killed by a flush does not start MC_BUSY.

## Timing
- Output decode is combinational from state and inputs; there is zero-cycle latency from a hazard to the stall.
- A multi-cycle op spends exactly MC_LAT cycles in EX. MC_BUSY lasts MC_LAT−1 cycles.
- A load-use stall inserts exactly one bubble. On the next cycle the load is in MEM and lu drops.
- Reset (asserted at any time, including mid-MC_BUSY):
  - state=RUN, cnt=0.
  - While rst_n=0, outputs are forced: pc_we=0, ifid_we=0, ifid_flush=1, idex_we=1, idex_bubble=1, mc_busy=0.
  - Counters are cleared to 0.
  - The first cycle after release is normal RUN.

## Configuration
- HAZARD_STATS_EN defined:
  - lu_cnt increments each RUN cycle with lu=1 and no branch.
  - flush_cnt increments each RUN cycle with ex_branch_taken=1.
  - mc_cnt increments each MC_BUSY cycle.
  - All three wrap modulo 2^32.
- HAZARD_STATS_EN undefined: the counters and their ports do not exist. Control behaviour is identical.

## Test plan
- Load-use: ex_mem_read=1, ex_dst=8, id_rs=8 → one cycle with pc_we=0, ifid_we=0, idex_bubble=1. The next cycle (ex_mem_read=0) all enables are 1.
- Register $0 and rt use: ex_dst=0, id_rs=0 → no stall. ex_dst=9, id_rt=9, id_uses_rt=0 → no stall; with id_uses_rt=1 → stall.
- Branch over hazard: ex_branch_taken=1 together with lu=1 → ifid_flush=1, idex_bubble=1, pc_we=1. With stats enabled, flush_cnt=1 and lu_cnt=0.
- Multi-cycle, MC_LAT=4: id_mc_op advances → mc_busy=1 and idex_we=0 for exactly 3 cycles, ignoring ex_branch_taken=1 pulsed mid-busy. Then RUN, and mc_cnt=3.
- Reset mid-MC_BUSY after one busy cycle: rst_n=0 → ifid_flush=1, idex_bubble=1, mc_busy=0 immediately (asynchronously). After release: RUN with all counters 0.
- MC_LAT=1 build: id_mc_op advances → mc_busy is never asserted and there are no stall cycles.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline scheduler for the 5-stage MIPS core: load-use stalls, branch flushes, multi-cycle EX holds.
// Optional hazard statistics counters are enabled by defining HAZARD_STATS_EN.
module pipeline_hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int REG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_mc_op,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             mc_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      lu_cnt,
  output logic [31:0]      flush_cnt,
  output logic [31:0]      mc_cnt
`endif
);

  typedef enum logic {
    RUN,
    MC_BUSY
  } state_t;

  localparam logic [REG_W-1:0] CNT_INIT = REG_W'(MC_LAT - 1);
  localparam logic [REG_W-1:0] CNT_ONE  = REG_W'(1);
  localparam bit               MC_HOLDS = (MC_LAT > 1);

  state_t           state;
  logic [REG_W-1:0] cnt;
  logic             lu;
  logic             mc_enter;

  assign lu = ex_mem_read && (ex_dst != '0) &&
              ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

  // A multi-cycle op only starts its hold if it actually advanced into EX this cycle.
  assign mc_enter = MC_HOLDS && (state == RUN) && id_mc_op && !ex_branch_taken && !lu;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_bubble = 1'b0;
    mc_busy     = 1'b0;
    if (!rst_n) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_we     = 1'b1;
      idex_bubble = 1'b1;
    end else if (state == MC_BUSY) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      mc_busy = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mc_enter) begin
            state <= MC_BUSY;
            cnt   <= CNT_INIT;
          end
        end
        MC_BUSY: begin
          // Leaving on cnt<=1 also recovers from an out-of-range zero count.
          if (cnt <= CNT_ONE) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt    <= '0;
      flush_cnt <= '0;
      mc_cnt    <= '0;
    end else begin
      if (state == RUN && ex_branch_taken) flush_cnt <= flush_cnt + 32'd1;
      if (state == RUN && lu && !ex_branch_taken) lu_cnt <= lu_cnt + 32'd1;
      if (state == MC_BUSY) mc_cnt <= mc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MC_LAT=4 instance plus an MC_LAT=1 instance).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_uses_rt = 1'b0;
  logic       id_mc_op = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_dst = '0;
  logic       ex_branch_taken = 1'b0;

  logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, mc_busy;
  logic pc_we1, ifid_we1, ifid_flush1, idex_we1, idex_bubble1, mc_busy1;
`ifdef HAZARD_STATS_EN
  logic [31:0] lu_cnt, flush_cnt, mc_cnt;
  logic [31:0] lu_cnt1, flush_cnt1, mc_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  // Output vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, mc_busy}
  localparam logic [5:0] V_RUN   = 6'b110100;
  localparam logic [5:0] V_LU    = 6'b000110;
  localparam logic [5:0] V_BR    = 6'b111110;
  localparam logic [5:0] V_BUSY  = 6'b000001;
  localparam logic [5:0] V_RESET = 6'b001110;

  pipeline_hazard_ctrl #(.MC_LAT(4), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_mc_op(id_mc_op), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .ex_branch_taken(ex_branch_taken), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_bubble(idex_bubble), .mc_busy(mc_busy)
`ifdef HAZARD_STATS_EN
    , .lu_cnt(lu_cnt), .flush_cnt(flush_cnt), .mc_cnt(mc_cnt)
`endif
  );

  pipeline_hazard_ctrl #(.MC_LAT(1), .REG_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_mc_op(id_mc_op), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .ex_branch_taken(ex_branch_taken), .pc_we(pc_we1), .ifid_we(ifid_we1),
    .ifid_flush(ifid_flush1), .idex_we(idex_we1), .idex_bubble(idex_bubble1), .mc_busy(mc_busy1)
`ifdef HAZARD_STATS_EN
    , .lu_cnt(lu_cnt1), .flush_cnt(flush_cnt1), .mc_cnt(mc_cnt1)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] vec4();
    return {26'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, mc_busy};
  endfunction

  function automatic logic [31:0] vec1();
    return {26'd0, pc_we1, ifid_we1, ifid_flush1, idex_we1, idex_bubble1, mc_busy1};
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                               input logic mc_op, input logic mem_read, input logic [4:0] dst,
                               input logic branch);
    @(negedge clk);
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rt      = uses_rt;
    id_mc_op        = mc_op;
    ex_mem_read     = mem_read;
    ex_dst          = dst;
    ex_branch_taken = branch;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #2;
    checkOutput("reset_outputs", vec4(), {26'd0, V_RESET});
`ifdef HAZARD_STATS_EN
    checkOutput("reset_lu_cnt", lu_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("run_after_reset", vec4(), {26'd0, V_RUN});

    applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
    checkOutput("lu_rs_stall", vec4(), {26'd0, V_LU});
    applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0);
    checkOutput("lu_released", vec4(), {26'd0, V_RUN});

    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
    checkOutput("r0_no_stall", vec4(), {26'd0, V_RUN});
    applyStimulus(5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
    checkOutput("rt_unused_no_stall", vec4(), {26'd0, V_RUN});
    applyStimulus(5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    checkOutput("rt_used_stall", vec4(), {26'd0, V_LU});
    checkOutput("rt_used_stall_lat1", vec1(), {26'd0, V_LU});

    applyStimulus(5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1);
    checkOutput("branch_over_lu", vec4(), {26'd0, V_BR});

    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("no_mc_after_stall_or_flush", vec4(), {26'd0, V_RUN});
`ifdef HAZARD_STATS_EN
    checkOutput("lu_cnt_after_hazards", lu_cnt, 32'd2);
    checkOutput("flush_cnt_after_branch", flush_cnt, 32'd1);
    checkOutput("mc_cnt_before_mc", mc_cnt, 32'd0);
`endif

    applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("mc_issue", vec4(), {26'd0, V_RUN});
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("mc_busy_1", vec4(), {26'd0, V_BUSY});
    checkOutput("lat1_no_busy_1", vec1(), {26'd0, V_RUN});
    applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
    checkOutput("mc_busy_2_ignores_branch_lu", vec4(), {26'd0, V_BUSY});
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("mc_busy_3", vec4(), {26'd0, V_BUSY});
    checkOutput("lat1_no_busy_3", vec1(), {26'd0, V_RUN});
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("mc_done_run", vec4(), {26'd0, V_RUN});
`ifdef HAZARD_STATS_EN
    checkOutput("mc_cnt_after_mc", mc_cnt, 32'd3);
    checkOutput("flush_cnt_unchanged_in_busy", flush_cnt, 32'd1);
    checkOutput("lu_cnt_unchanged_in_busy", lu_cnt, 32'd2);
`endif

    applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("mc_issue_2", vec4(), {26'd0, V_RUN});
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("mc_busy_before_reset", vec4(), {26'd0, V_BUSY});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_mid_busy", vec4(), {26'd0, V_RESET});
`ifdef HAZARD_STATS_EN
    checkOutput("reset_mc_cnt", mc_cnt, 32'd0);
    checkOutput("reset_flush_cnt", flush_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("run_after_release", vec4(), {26'd0, V_RUN});
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("still_run_after_release", vec4(), {26'd0, V_RUN});
    applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
    checkOutput("lu_after_release", vec4(), {26'd0, V_LU});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
